div16u_seq: RTL and testbench



---
 rtl/div16u_seq.sv | 94 +++++++++
 tb/tb_div16u_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/div16u_seq.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per cycle,
// with valid/ready handshakes on request and result sides.
`timescale 1ns/1ps
module div16u_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] dvd;
  logic [7:0]  dvs;
  logic [7:0]  p;
  logic [3:0]  cnt;
  logic [8:0]  t;
  logic        qbit;
  logic [7:0]  p_nxt;

  // The compare is done on 9 bits, but the remainder after a successful
  // subtract is always below the divisor, so the low 8 bits suffice.
  always_comb begin
    t     = {p, dvd[15]};
    qbit  = (t >= {1'b0, dvs});
    p_nxt = qbit ? (t[7:0] - dvs) : t[7:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (B == 8'd0) ? DONE : BUSY;
      BUSY: if (cnt == 4'd0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd <= '0;
      dvs <= '0;
      p   <= '0;
      cnt <= '0;
      Q   <= '0;
      R   <= '0;
      dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd <= A;
            dvs <= B;
            p   <= '0;
            cnt <= 4'd15;
            if (B == 8'd0) begin
              Q  <= '1;
              R  <= A[7:0];
              dz <= 1'b1;
            end
          end
        end
        BUSY: begin
          p   <= p_nxt;
          dvd <= {dvd[14:0], qbit};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            Q  <= {dvd[14:0], qbit};
            R  <= p_nxt;
            dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div16u_seq.sv
// Directed bench for div16u_seq: latency, boundary quotients, divide-by-zero,
// back-pressure, async reset abort, and a short randomized golden-model sweep.
`timescale 1ns/1ps
module tb_div16u_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        dz;

  int checks = 0;
  int errors = 0;

  div16u_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .dz(dz)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One transaction; bp = cycles out_ready is held low once out_valid is seen.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input int bp);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    int          lat, explat, w;
    if (b == 8'd0) begin
      eq = 16'hFFFF; er = a[7:0]; ed = 1'b1; explat = 0;
    end else begin
      eq = a / {8'd0, b}; er = 8'(a % {8'd0, b}); ed = 1'b0; explat = 16;
    end
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1; out_ready = (bp == 0);
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; A = 16'($urandom); B = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      A = 16'($urandom); B = 8'($urandom);
    end
    chk("latency", 32'(lat), 32'(explat));
    chk("Q", 32'(Q), 32'(eq));
    chk("R", 32'(R), 32'(er));
    chk("dz", 32'(dz), 32'(ed));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_Q", 32'(Q), 32'(eq));
      chk("bp_R", 32'(R), 32'(er));
      chk("bp_dz", 32'(dz), 32'(ed));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("handoff_valid", 32'(out_valid), 32'd0);
    chk("handoff_ready", 32'(in_ready), 32'd1);
    chk("hold_Q", 32'(Q), 32'(eq));
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    do_div(16'd1000, 8'd7, 0);
    do_div(16'd65535, 8'd1, 0);
    do_div(16'd65535, 8'd255, 0);
    do_div(16'd3, 8'd200, 0);
    do_div(16'd5, 8'd0, 0);
    do_div(16'd100, 8'd10, 0);
    do_div(16'd12345, 8'd99, 5);

    // Abort mid-iteration with an asynchronous reset.
    @(negedge clk);
    A = 16'd40000; B = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_Q", 32'(Q), 32'd0);
    chk("abort_R", 32'(R), 32'd0);
    chk("abort_dz", 32'(dz), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; A = 16'd7; B = 8'd0;
    @(posedge clk); #1;
    chk("rst_ignore_valid", 32'(out_valid), 32'd0);
    chk("rst_ignore_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    do_div(16'd40000, 8'd3, 0);

    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      do_div(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
